irq_ctrl: RTL and testbench

Programmable interrupt controller between the interrupt sources (TC0, TC1, external `interrupt`, spares) and the CPU's `i_HWInt` input. It latches edge- or level-type requests, applies a per-source mask and presents the masked pending vector to the CPU. It is also a memory-mapped peripheral behind the bridge, with the same Addr/WE/Din/Dout port style as TC. Software uses it to acknowledge edge requests, select trigger modes, find the highest-priority active source and count dropped edges.

---
 rtl/irq_ctrl.sv | 103 ++++++++++
 tb/tb_irq_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: edge/level request latching, per-source mask,
// lowest-index priority, software ACK and a saturating dropped-edge counter.
module irq_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] Src,
  input  logic [29:0]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic [N_SRC-1:0] HWInt,
  output logic [2:0]       Top,
  output logic             Any
);

  localparam logic [2:0] OFF_PEND = 3'd0;
  localparam logic [2:0] OFF_MASK = 3'd1;
  localparam logic [2:0] OFF_MODE = 3'd2;
  localparam logic [2:0] OFF_ACK  = 3'd3;
  localparam logic [2:0] OFF_TOP  = 3'd4;
  localparam logic [2:0] OFF_LOST = 3'd5;

  logic [N_SRC-1:0] src_q, src_p;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [15:0]      lost_q, lost_d;

  logic [2:0]       off;
  logic [N_SRC-1:0] din_n, rise, ack, mode_chg, edge_nxt;
  logic             wr_mask, wr_mode, wr_lost, lost_hit;
  logic             unused_bits;

  assign off         = Addr[2:0];
  assign din_n       = Din[N_SRC-1:0];
  assign unused_bits = ^{Addr[29:3], Din};

  assign wr_mask  = WE && (off == OFF_MASK);
  assign wr_mode  = WE && (off == OFF_MODE);
  assign wr_lost  = WE && (off == OFF_LOST);
  assign ack      = (WE && (off == OFF_ACK)) ? din_n : '0;
  assign mode_chg = wr_mode ? (mode_q ^ din_n) : '0;

  assign rise     = src_q & ~src_p;
  assign edge_nxt = rise | (pend_q & ~ack);

  // A bit switching mode restarts from empty, but a coincident rise still latches.
  assign pend_d = (mode_chg & rise) |
                  (~mode_chg & ((mode_q & edge_nxt) | (~mode_q & src_q)));
  assign mask_d = wr_mask ? din_n : mask_q;
  assign mode_d = wr_mode ? din_n : mode_q;

  // Dropped edge: a rise on an already-pending edge bit that is not being cleared.
  assign lost_hit = |(mode_q & rise & pend_q & ~ack);

  always_comb begin
    lost_d = lost_q;
    if (wr_lost)                         lost_d = '0;
    else if (lost_hit && lost_q != 16'hFFFF) lost_d = lost_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= '0;
      src_p  <= '0;
      pend_q <= '0;
      mask_q <= '0;
      mode_q <= '0;
      lost_q <= '0;
    end else begin
      src_q  <= Src;
      src_p  <= src_q;
      pend_q <= pend_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
      lost_q <= lost_d;
    end
  end

  assign HWInt = pend_q & mask_q;
  assign Any   = |HWInt;

  always_comb begin
    Top = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (HWInt[i]) Top = 3'(i);
  end

  always_comb begin
    Dout = 32'd0;
    case (off)
      OFF_PEND: Dout = {{(32-N_SRC){1'b0}}, pend_q};
      OFF_MASK: Dout = {{(32-N_SRC){1'b0}}, mask_q};
      OFF_MODE: Dout = {{(32-N_SRC){1'b0}}, mode_q};
      OFF_TOP:  Dout = Any ? ({29'd0, Top} + 32'd1) : 32'd0;
      OFF_LOST: Dout = {16'd0, lost_q};
      default:  Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal checks plus a random phase,
// all cycles compared against a per-source behavioural model.
module tb_irq_ctrl;
  localparam int N = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  Src;
  logic [29:0]   Addr;
  logic          WE;
  logic [31:0]   Din;
  logic [31:0]   Dout;
  logic [N-1:0]  HWInt;
  logic [2:0]    Top;
  logic          Any;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  irq_ctrl #(.N_SRC(N)) dut (
    .clk(clk), .reset(reset), .Src(Src), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .HWInt(HWInt), .Top(Top), .Any(Any)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit m_sq[N], m_sp[N], m_pend[N], m_mask[N], m_mode[N];
  int m_lost;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_sq[i] = 0; m_sp[i] = 0; m_pend[i] = 0; m_mask[i] = 0; m_mode[i] = 0;
      end
      m_lost = 0;
    end else begin
      bit dropped;
      bit np[N];
      bit nmode[N];
      dropped = 0;
      for (int i = 0; i < N; i++) begin
        bit r, a;
        r = m_sq[i] && !m_sp[i];
        a = WE && (Addr[2:0] == 3) && Din[i];
        nmode[i] = (WE && Addr[2:0] == 2) ? Din[i] : m_mode[i];
        if (m_mode[i] && r && m_pend[i] && !a) dropped = 1;
        if (nmode[i] != m_mode[i]) np[i] = r;
        else if (m_mode[i])        np[i] = r || (m_pend[i] && !a);
        else                       np[i] = m_sq[i];
      end
      if (WE && Addr[2:0] == 5)           m_lost = 0;
      else if (dropped && m_lost < 65535) m_lost = m_lost + 1;
      for (int i = 0; i < N; i++) begin
        m_pend[i] = np[i];
        m_mode[i] = nmode[i];
        if (WE && Addr[2:0] == 1) m_mask[i] = Din[i];
        m_sp[i] = m_sq[i];
        m_sq[i] = Src[i];
      end
    end
  end

  function automatic logic [31:0] vec(input bit v[N]);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < N; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic int exp_top();
    for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_dout(input logic [2:0] off);
    int t;
    t = exp_top();
    case (off)
      0: return vec(m_pend);
      1: return vec(m_mask);
      2: return vec(m_mode);
      4: return (t < 0) ? 32'd0 : 32'(t + 1);
      5: return 32'(m_lost);
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      int t;
      t = exp_top();
      chk("model_hwint", 32'(HWInt), vec(m_pend) & vec(m_mask));
      chk("model_any",   32'(Any),   32'(t >= 0));
      chk("model_top",   32'(Top),   (t < 0) ? 32'd0 : 32'(t));
      chk("model_dout",  Dout,       exp_dout(Addr[2:0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    Addr = 30'(off); Din = d; WE = 1'b1;
    tick();
    WE = 1'b0; Din = '0;
  endtask

  task automatic rd(input string name, input int off, input logic [31:0] exp);
    Addr = 30'(off);
    #1;
    chk(name, Dout, exp);
  endtask

  task automatic pulse(input int b);
    Src[b] = 1'b1; tick();
    Src[b] = 1'b0; tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; Src = '0; Addr = '0; WE = 1'b0; Din = '0;
    tick(); tick(); tick();
    reset = 1'b0;
    started = 1;

    // Reset state
    for (int o = 0; o < 8; o++) rd("reset_dout", o, 32'd0);
    chk("reset_hwint", 32'(HWInt), 32'd0);
    chk("reset_any", 32'(Any), 32'd0);

    // Single edge pulse on bit 0
    wr(1, 32'h3F); wr(2, 32'h01);
    Src[0] = 1'b1; tick();
    chk("edge_lat1", 32'(HWInt), 32'h00);
    Src[0] = 1'b0; tick();
    chk("edge_lat2", 32'(HWInt), 32'h01);
    tick(); tick();
    chk("edge_hold", 32'(HWInt), 32'h01);
    rd("edge_top", 4, 32'd1);
    wr(3, 32'h01);
    chk("edge_ack", 32'(HWInt), 32'h00);
    wr(3, 32'h01);
    chk("edge_ack2", 32'(HWInt), 32'h00);

    // Level mode on bit 2
    wr(2, 32'h00); wr(1, 32'h04);
    Src[2] = 1'b1; tick();
    chk("lvl_lat1", 32'(HWInt), 32'h00);
    tick();
    chk("lvl_lat2", 32'(HWInt), 32'h04);
    wr(3, 32'h04);
    chk("lvl_ack_noeff", 32'(HWInt), 32'h04);
    tick(); tick();
    Src[2] = 1'b0; tick();
    chk("lvl_fall1", 32'(HWInt), 32'h04);
    tick();
    chk("lvl_fall2", 32'(HWInt), 32'h00);

    // Priority between edge bits 0 and 1
    wr(2, 32'h03); wr(1, 32'h3F);
    pulse(1);
    rd("prio_top2", 4, 32'd2);
    pulse(0);
    rd("prio_top1", 4, 32'd1);
    wr(3, 32'h01);
    rd("prio_ack0", 4, 32'd2);
    wr(3, 32'h02);
    chk("prio_none", 32'(Any), 32'd0);

    // Dropped edges
    wr(5, 32'h0);
    pulse(0); pulse(0); pulse(0);
    rd("lost_two", 5, 32'd2);
    Src[0] = 1'b1; tick();
    Src[0] = 1'b0; Addr = 30'd5; Din = 32'hFFFF; WE = 1'b1; tick();
    WE = 1'b0; tick();
    rd("lost_wr_wins", 5, 32'd0);

    // ACK coinciding with rise
    Src[0] = 1'b1; tick();
    Src[0] = 1'b0; Addr = 30'd3; Din = 32'h01; WE = 1'b1; tick();
    WE = 1'b0; tick();
    rd("ackrise_pend", 0, 32'h01);
    rd("ackrise_lost", 5, 32'd0);

    // Saturation: two sources rising on alternate cycles give one loss per cycle
    for (int n = 0; n < 65600; n++) begin
      Src = n[0] ? 6'b000001 : 6'b000010;
      tick();
    end
    Src = '0; tick(); tick();
    rd("lost_sat", 5, 32'hFFFF);
    pulse(0);
    rd("lost_sat_hold", 5, 32'hFFFF);

    // Random phase, including mid-run resets with sources held high
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) Src[i] = ~Src[i];
      WE    = ($urandom_range(0, 3) == 0);
      Addr  = 30'($urandom);
      Din   = $urandom;
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; WE = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
